flex_timer_arbiter: RTL and testbench
=====================================

// Module: flex_timer_arbiter
// PURPOSE
//  Shares one flex counting resource between NUM_REQ requesters. Each requester asks for a timed
//  interval of req_len cycles. The block grants the counter round-robin and runs the count.
//  It then pulses a per-requester done. It sits between protocol FSMs (UART/USB bit timers)
//  and the shared timebase.
// PARAMETERS
//  NUM_REQ      4  number of requesters (>=2)
//  NUM_CNT_BITS 8  counter / interval-length width
// PORTS
//  clk         in   1                     system clock, all logic on rising edge
//  rst         in   1                     synchronous, active-high reset
//  req         in   NUM_REQ               per-requester interval request (level)
//  req_len     in   NUM_REQ*NUM_CNT_BITS  interval length; slice i = requester i
//  abort       in   1                     cancel interval in progress
//  grant       out  NUM_REQ               one-hot owner of counter, 0 when idle
//  done        out  NUM_REQ               one-cycle completion pulse to owner
//  busy        out  1                     state != IDLE
//  count_out   out  NUM_CNT_BITS          current count of running interval
//  near_done   out  1                     optional early warning (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset:
//    - Reset is synchronous and active-high.
//    - rst=1 at an edge forces state=IDLE and grant=0, done=0, busy=0, count_out=0, near_done=0.
//    - rst=1 also sets rr_ptr so requester 0 has highest priority first.
//    - rst overrides every other input, including mid-interval; no done is issued.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE:
//    - If any req bit is set, pick the first set bit searching from rr_ptr upward, with wrap.
//    - Next cycle: RUN, grant=onehot(winner), count_out=1.
//    - Latch len = req_len slice of the winner. A latched len of 0 is treated as 1.
//  - RUN:
//    - count_out increments by 1 each cycle.
//    - When count_out==len, the next state is DONE and count_out holds.
//    - req/req_len changes during RUN are ignored; the length is latched.
//  - DONE:
//    - done[winner]=1 for exactly this cycle, with grant still asserted.
//    - Next cycle: IDLE, grant=0, count_out=0.
//    - rr_ptr = winner+1 mod NUM_REQ, so the just-served requester is lowest priority next.
//  - Latency:
//    - req sampled high in IDLE -> grant the next cycle.
//    - done asserts len cycles after grant rises.
//    - grant is high for len+1 cycles.
//    - At least one IDLE cycle separates consecutive grants.
//  - Requester protocol: the requester deasserts req in the cycle after done. A req still high
//    in IDLE is re-arbitrated at its new (lower) priority.
//  - abort:
//    - In RUN or DONE, abort returns to IDLE next cycle with grant=0, count_out=0 and no done pulse.
//    - rr_ptr still advances past the aborted winner.
//    - abort in IDLE is ignored and blocks no new grant.
//  - Simultaneous events:
//    - abort in the same cycle as count_out==len: abort wins, no done.
//    - rst together with abort: reset wins.
//  - Arithmetic: count_out never exceeds len and never wraps. Full NUM_CNT_BITS range is allowed
//    (len=2^N-1).
// CONFIGURATION
//  FLEX_ARB_NEAR_DONE_EN defined:
//    - near_done=1 in the RUN cycle where count_out==len-1.
//    - When len<=1, near_done=1 on the first RUN cycle.
//    - Cleared by abort/rst along with the interval.
//  Not defined: near_done is tied to 0; port retained, no extra flops.
// TESTING
//  1. rst, then req=4'b0001, len0=5 -> grant=0001 next cycle; count 1..5; done[0] in the 6th
//     grant cycle; busy low after.
//  2. req=4'b1111 held, all len=2 -> grants 0001,0010,0100,1000,0001 with one IDLE gap each.
//  3. req[2], len2=0 -> treated as 1: grant 2 cycles, done[2] on the 2nd.
//  4. len=8, abort at count_out=3 -> IDLE next cycle, no done. A pending req[1] is granted the
//     cycle after.
//  5. abort at count_out==len, and rst at count_out=4 -> no done; all outputs 0 the next cycle.
//  6. FLEX_ARB_NEAR_DONE_EN, len=6 -> near_done only at count_out=5. Without the macro,
//     near_done stays 0 throughout.

Source files
------------

// File: rtl/flex_timer_arbiter.sv
// Round-robin arbiter granting one shared interval counter among NUM_REQ requesters.
// Optional macro FLEX_ARB_NEAR_DONE_EN enables the near_done early warning output.
module flex_timer_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_CNT_BITS = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_len,
   input  logic                            abort,
   output logic [NUM_REQ-1:0]              grant,
   output logic [NUM_REQ-1:0]              done,
   output logic                            busy,
   output logic [NUM_CNT_BITS-1:0]         count_out,
   output logic                            near_done
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]        winner, winner_nxt, winner_inc;
   logic [PTR_W-1:0]        pick, scan_idx;
   logic                    pick_vld;
   logic [NUM_CNT_BITS-1:0] len_q, len_nxt, len_sel;
   logic [NUM_CNT_BITS-1:0] cnt_q, cnt_nxt;

   // First requesting index at or after rr_ptr, wrapping around
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      scan_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_idx = PTR_W'((32'(rr_ptr) + i) % 32'(NUM_REQ));
         if (!pick_vld && req[scan_idx]) begin
            pick     = scan_idx;
            pick_vld = 1'b1;
         end
      end
   end

   assign winner_inc = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
   assign len_sel    = req_len[int'(pick)*NUM_CNT_BITS +: NUM_CNT_BITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         winner <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         winner <= winner_nxt;
         len_q  <= len_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      winner_nxt = winner;
      len_nxt    = len_q;
      cnt_nxt    = cnt_q;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt  = RUN;
               winner_nxt = pick;
               cnt_nxt    = NUM_CNT_BITS'(1);
               len_nxt    = (len_sel == '0) ? NUM_CNT_BITS'(1) : len_sel;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt  = IDLE;
               cnt_nxt    = '0;
               rr_ptr_nxt = winner_inc;
            end else if (cnt_q == len_q) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            rr_ptr_nxt = winner_inc;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // done is suppressed combinationally when abort arrives in the DONE cycle
   always_comb begin
      grant     = '0;
      done      = '0;
      busy      = (state != IDLE);
      count_out = cnt_q;
      if (state != IDLE)
         grant[winner] = 1'b1;
      if (state == DONE && !abort)
         done[winner] = 1'b1;
`ifdef FLEX_ARB_NEAR_DONE_EN
      near_done = (state == RUN) && (len_q == NUM_CNT_BITS'(1) || cnt_q == len_q - 1'b1);
`else
      near_done = 1'b0;
`endif
   end

endmodule

// File: tb/tb_flex_timer_arbiter.sv
// Self-checking bench for flex_timer_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (owner / elapsed-cycle bookkeeping).
module tb_flex_timer_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_len;
   logic           abort;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   count_out;
   logic           near_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: owner = -1 when idle; elapsed counts grant cycles starting at 1
   int m_owner = -1;
   int m_elapsed = 0;
   int m_len = 0;
   int m_ptr = 0;

   flex_timer_arbiter #(.NUM_REQ(N), .NUM_CNT_BITS(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_len(req_len), .abort(abort),
      .grant(grant), .done(done), .busy(busy), .count_out(count_out), .near_done(near_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef FLEX_ARB_NEAR_DONE_EN
   localparam bit NEAR_EN = 1'b1;
`else
   localparam bit NEAR_EN = 1'b0;
`endif

   task automatic tick();
      logic [N-1:0]   r;
      logic [N*W-1:0] rl;
      logic           ab, rs;
      logic [W-1:0]   sl;
      bit             found;
      r = req; rl = req_len; ab = abort; rs = rst;
      @(posedge clk);
      if (rs) begin
         m_owner = -1; m_ptr = 0; m_elapsed = 0;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (!found && r[k]) begin
               found = 1'b1;
               m_owner = k;
               sl = rl[k*W +: W];
               m_len = (sl == 0) ? 1 : int'(sl);
               m_elapsed = 1;
            end
         end
      end else if (ab || m_elapsed == m_len + 1) begin
         m_ptr = (m_owner + 1) % N;
         m_owner = -1;
      end else begin
         m_elapsed++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; req_len = '0; abort = 1'b0;
      tick(); tick();
      n_checks++;
      if ({grant, done, busy, count_out, near_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: grant=%b done=%b busy=%b count=%0d near=%b, required all 0",
                  grant, done, busy, count_out, near_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      req = 4'b0001; req_len = '0; req_len[0 +: W] = 8'd5;
      tick();
      req = '0;
      for (int k = 1; k <= 5; k++) begin
         n_checks++;
         if (grant !== 4'b0001 || count_out !== W'(k) || done !== '0) begin
            n_fail++;
            $display("FAIL single_run: grant=%b count=%0d done=%b, required 0001/%0d/0000",
                     grant, count_out, done, k);
         end
         tick();
      end
      n_checks++;
      if (done !== 4'b0001 || grant !== 4'b0001 || count_out !== 8'd5) begin
         n_fail++;
         $display("FAIL single_done: done=%b grant=%b count=%0d, required 0001/0001/5",
                  done, grant, count_out);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || grant !== '0 || count_out !== '0 || done !== '0) begin
         n_fail++;
         $display("FAIL single_idle: busy=%b grant=%b count=%0d done=%b, required 0/0000/0/0000",
                  busy, grant, count_out, done);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g;
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < N; i++) req_len[i*W +: W] = 8'd2;
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % N);
         tick();
         n_checks++;
         if (grant !== exp_g || count_out !== 8'd1) begin
            n_fail++;
            $display("FAIL rr_grant%0d: grant=%b count=%0d, required %b/1", g, grant, count_out, exp_g);
         end
         tick(); tick();
         n_checks++;
         if (done !== exp_g) begin
            n_fail++;
            $display("FAIL rr_done%0d: done=%b, required %b", g, done, exp_g);
         end
         tick();
         n_checks++;
         if (grant !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap%0d: grant=%b busy=%b, required 0000/0", g, grant, busy);
         end
      end
      req = '0;
   endtask

   task automatic test_zero_len();
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0100; req_len = '0;
      tick();
      req = '0;
      n_checks++;
      if (grant !== 4'b0100 || done !== '0 || count_out !== 8'd1) begin
         n_fail++;
         $display("FAIL zlen_first: grant=%b done=%b count=%0d, required 0100/0000/1", grant, done, count_out);
      end
      tick();
      n_checks++;
      if (grant !== 4'b0100 || done !== 4'b0100) begin
         n_fail++;
         $display("FAIL zlen_done: grant=%b done=%b, required 0100/0100", grant, done);
      end
      tick();
      n_checks++;
      if (grant !== '0) begin
         n_fail++;
         $display("FAIL zlen_idle: grant=%b, required 0000", grant);
      end
   endtask

   task automatic test_abort();
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0011; req_len = '0; req_len[0 +: W] = 8'd8; req_len[W +: W] = 8'd3;
      tick(); tick(); tick();
      n_checks++;
      if (count_out !== 8'd3 || grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL abort_pre: count=%0d grant=%b, required 3/0001", count_out, grant);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (grant !== '0 || busy !== 1'b0 || done !== '0 || count_out !== '0) begin
         n_fail++;
         $display("FAIL abort_idle: grant=%b busy=%b done=%b count=%0d, required 0000/0/0000/0",
                  grant, busy, done, count_out);
      end
      tick();
      n_checks++;
      if (grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL abort_next: grant=%b, required 0010", grant);
      end
      req = '0;
   endtask

   task automatic test_abort_at_len_and_rst();
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0001; req_len = '0; req_len[0 +: W] = 8'd3;
      tick(); tick(); tick();
      abort = 1'b1;
      n_checks++;
      if (count_out !== 8'd3 || done !== '0) begin
         n_fail++;
         $display("FAIL abortlen_pre: count=%0d done=%b, required 3/0000", count_out, done);
      end
      tick();
      abort = 1'b0;
      n_checks++;
      if (done !== '0 || grant !== '0) begin
         n_fail++;
         $display("FAIL abortlen_after: done=%b grant=%b, required 0000/0000", done, grant);
      end
      req_len[0 +: W] = 8'd5;
      tick(); tick(); tick(); tick();
      n_checks++;
      if (count_out !== 8'd4 || grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL rstmid_pre: count=%0d grant=%b, required 4/0001", count_out, grant);
      end
      rst = 1'b1; abort = 1'b1;
      tick();
      rst = 1'b0; abort = 1'b0; req = '0;
      n_checks++;
      if ({grant, done, busy, count_out, near_done} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_after: grant=%b done=%b busy=%b count=%0d near=%b, required all 0",
                  grant, done, busy, count_out, near_done);
      end
   endtask

   task automatic test_near_done();
      logic exp_n;
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0001; req_len = '0; req_len[0 +: W] = 8'd6;
      tick();
      req = '0;
      for (int k = 1; k <= 7; k++) begin
         exp_n = NEAR_EN && (k == 5);
         n_checks++;
         if (near_done !== exp_n) begin
            n_fail++;
            $display("FAIL near_done_c%0d: near_done=%b, required %b", k, near_done, exp_n);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] eg, ed;
      logic [W-1:0] ec;
      logic         en;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         req   = N'($urandom);
         abort = ($urandom_range(0, 99) < 4);
         rst   = ($urandom_range(0, 999) < 5);
         for (int i = 0; i < N; i++)
            req_len[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 1)) : W'($urandom_range(0, 12));
         if ($urandom_range(0, 199) == 0) req_len[0 +: W] = 8'd255;
         tick();
         eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
         ec = (m_owner < 0) ? '0 : W'((m_elapsed > m_len) ? m_len : m_elapsed);
         ed = (m_owner >= 0 && m_elapsed == m_len + 1 && !abort) ? eg : '0;
         en = NEAR_EN && m_owner >= 0 && m_elapsed <= m_len &&
              (m_elapsed == ((m_len > 1) ? m_len - 1 : 1));
         n_checks++;
         if (grant !== eg) begin
            n_fail++;
            $display("FAIL rand_grant c%0d: grant=%b, required %b", c, grant, eg);
         end
         n_checks++;
         if (count_out !== ec) begin
            n_fail++;
            $display("FAIL rand_count c%0d: count=%0d, required %0d", c, count_out, ec);
         end
         n_checks++;
         if (done !== ed) begin
            n_fail++;
            $display("FAIL rand_done c%0d: done=%b, required %b", c, done, ed);
         end
         n_checks++;
         if (busy !== (m_owner >= 0)) begin
            n_fail++;
            $display("FAIL rand_busy c%0d: busy=%b, required %b", c, busy, m_owner >= 0);
         end
         n_checks++;
         if (near_done !== en) begin
            n_fail++;
            $display("FAIL rand_near c%0d: near_done=%b, required %b", c, near_done, en);
         end
      end
      rst = 1'b0; abort = 1'b0; req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_abort();
      test_abort_at_len_and_rst();
      test_near_done();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
